ampel_sequencer: RTL
====================

# ampel_sequencer

Timed sequencer for the traffic light: drives the 3-bit `counter` (step 0–7) and the matching `ampelfarbe` code. It handles the pedestrian button (`knopf`) by latching a request and holding the red phase for a programmable extension. It is the source side of the counter/colour interface, and replaces the free-running testbench counter in `main`.

## Interface
- `CLK_PER_STEP`, default 50: clock cycles per counter step; legal values are ≥ 1.
- `EXT_STEPS`, default 8: extra step durations that step 5 is held when a request is served; legal values are ≥ 1.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `knopf`  in  1  pedestrian button. It is asynchronous to `clk` and level-driven.
- `counter`  out  3  current step, 0–7.
- `ampelfarbe`  out  2  colour code: 00 green, 01 yellow, 10 red, 11 red & yellow.
- `req_pending`  out  1  a button request is latched and not yet served.
- `ext_active`  out  1  a red extension is in progress.
- `knopf_ack`  out  1  one-cycle pulse when an extension starts.

## Operation
- **Colour map.** This mapping is fixed: step 0→11, 1→00, 2→00, 3→01, 4→01, 5→10, 6→10, 7→10.
- **Step timer.** `tmr` counts from 0 to CLK_PER_STEP−1. A "tick" is the cycle in which `tmr` is at its terminal value; on a tick, `tmr` wraps to 0.
- **RUN state.** On each tick, `counter` advances by 1 modulo 8, so 7 wraps to 0.
- **Starting an extension.** On the tick that advances `counter` from 4 to 5, if `req_pending` is set or a button edge is detected in that same cycle:
  - the state goes to EXTEND,
  - `ext_left` is loaded with EXT_STEPS,
  - `knopf_ack` pulses,
  - `req_pending` is cleared.
- **EXTEND state.**
  - `counter` is held at 5 and `ext_active` is 1.
  - Each tick decrements `ext_left`.
  - On the tick where `ext_left` is 1, the state returns to RUN. `counter` stays at 5 for one more normal step, then continues to 6 and 7.
- **Button input.**
  - `knopf` passes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge seen in RUN sets `req_pending`; this includes edges during steps 5–7, which are served at the next 4→5 transition.
  - An edge seen in EXTEND is ignored.
  - A level held high produces exactly one request.
- **Output registers.** `ampelfarbe` is registered and decoded from the next value of `counter`, so both outputs change on the same edge.

## Timing
- **Reset values:**
  - `counter`=0, `ampelfarbe`=11, `tmr`=0
  - state RUN, `ext_left`=0
  - `req_pending`=0, `ext_active`=0, `knopf_ack`=0
- **Reset behaviour.**
  - Reset takes effect immediately when `rst_n` falls, independent of the clock, including in the middle of an extension. Any pending request is discarded.
  - After reset is released, the first tick occurs CLK_PER_STEP cycles later.
- **Normal cycle.** Each step lasts CLK_PER_STEP cycles; a full cycle is 8·CLK_PER_STEP cycles.
- **Extended cycle.** Step 5 lasts (EXT_STEPS+1)·CLK_PER_STEP cycles; the extended cycle is (8+EXT_STEPS)·CLK_PER_STEP cycles.
- **Button latency.** A `knopf` rising edge sets `req_pending` on the 3rd rising `clk` edge after it; the 3 cycles are made up of 2 synchronizer stages and 1 edge register.
  - Pulses shorter than one `clk` period may be lost.
- **Handshake timing.** `knopf_ack` and `ext_active` rise on the same edge that sets `counter` to 5.
  - `req_pending` falls on that same edge.
  - `knopf_ack` is high for exactly 1 cycle.
- **Simultaneous events.** If an edge is detected and the 4→5 tick occur in the same cycle, the extension starts, and `req_pending` stays 0 throughout.
- **CLK_PER_STEP=1.** Every cycle is a tick; the behaviour is otherwise identical.
- **Counter widths.**
  - `tmr` is $clog2(CLK_PER_STEP) bits, minimum 1.
  - `ext_left` is $clog2(EXT_STEPS+1) bits.

## Structure
- **Package `ampel_pkg`:**
  - colour constants GRUEN=00, GELB=01, ROT=10, ROT_GELB=11,
  - the state enum (RUN, EXTEND),
  - function `farbe_of(counter)` implementing the colour map. The combinational Ampel variants also use this function.
- **Sub-module `ampel_knopf_sync`:** the 2-FF synchronizer plus rising-edge detector. It outputs a 1-cycle `knopf_edge`, and resets asynchronously to 0.
- **`ampel_sequencer` itself:** the FSM, step timer, extension counter, request latch and output registers.

## Test plan
All scenarios use CLK_PER_STEP=4 and EXT_STEPS=2.
1. **Free run.** Release reset with `knopf` held at 0 → `counter` steps 0,1,…,7,0 every 4 cycles; `ampelfarbe` follows 11,00,00,01,01,10,10,10; the period is 32 cycles; `ext_active` stays 0.
2. **Single request.** A 3-cycle `knopf` pulse at step 1 → `req_pending`=1 three edges later. At the 4→5 edge, `knopf_ack` is a 1-cycle pulse and `req_pending`=0. `counter`=5 for 12 cycles, then 6 and 7 for 4 cycles each. Red lasts 20 cycles in total.
3. **Late and ignored presses.**
   - A press during EXTEND → `req_pending` stays 0, and the next cycle runs normally (32 cycles).
   - A press at step 6 in RUN → it is served at the next 4→5 transition.
4. **Coincident edge.** Align the synchronized edge with the 4→5 tick → the extension starts on that transition and `req_pending` never goes to 1.
5. **Reset mid-extension.** Drop `rst_n` at step 5 in EXTEND, between clock edges → `counter`=0, `ampelfarbe`=11, and `ext_active`/`req_pending`/`knopf_ack` all 0 without waiting for a clock. After release, the free-run sequence is as in scenario 1.
6. **Held button.** Hold `knopf` at 1 for 100 cycles → exactly one `knopf_ack` and one extension.

Source files
------------

// File: rtl/ampel_pkg.sv
// Shared types and the fixed step-to-colour map for the traffic light.
package ampel_pkg;

    localparam int unsigned STEP_W  = 3;
    localparam int unsigned FARBE_W = 2;

    localparam logic [FARBE_W-1:0] GRUEN    = 2'b00;
    localparam logic [FARBE_W-1:0] GELB     = 2'b01;
    localparam logic [FARBE_W-1:0] ROT      = 2'b10;
    localparam logic [FARBE_W-1:0] ROT_GELB = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        EXTEND = 1'b1
    } state_t;

    function automatic logic [FARBE_W-1:0] farbe_of(input logic [STEP_W-1:0] counter);
        logic [FARBE_W-1:0] farbe;
        case (counter)
            3'd0:          farbe = ROT_GELB;
            3'd1, 3'd2:    farbe = GRUEN;
            3'd3, 3'd4:    farbe = GELB;
            default:       farbe = ROT;
        endcase
        return farbe;
    endfunction

endpackage

// File: rtl/ampel_sequencer_if.sv
// Counter/colour interface between the sequencer (master) and its consumers.
interface ampel_sequencer_if;
    import ampel_pkg::*;

    logic [STEP_W-1:0]  counter;
    logic [FARBE_W-1:0] ampelfarbe;
    logic               req_pending;
    logic               ext_active;
    logic               knopf_ack;

    modport master (
        output counter,
        output ampelfarbe,
        output req_pending,
        output ext_active,
        output knopf_ack
    );

    modport slave (
        input counter,
        input ampelfarbe,
        input req_pending,
        input ext_active,
        input knopf_ack
    );
endinterface

// File: rtl/ampel_knopf_sync.sv
// Two-stage synchronizer for the asynchronous button plus a rising-edge detector.
module ampel_knopf_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic knopf,
    output logic knopf_edge
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            meta_q     <= knopf;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign knopf_edge = sync_q & ~sync_dly_q;

endmodule

// File: rtl/ampel_sequencer.sv
// Timed traffic-light step sequencer with a latched pedestrian request that
// stretches the red phase by EXT_STEPS step durations.
module ampel_sequencer
    import ampel_pkg::*;
#(
    parameter int unsigned CLK_PER_STEP = 50,
    parameter int unsigned EXT_STEPS    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               knopf,
    ampel_sequencer_if.master  bus
);

    localparam int unsigned TMR_W = (CLK_PER_STEP > 1) ? $clog2(CLK_PER_STEP) : 1;
    localparam int unsigned EXT_W = $clog2(EXT_STEPS + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLK_PER_STEP - 1);
    localparam logic [EXT_W-1:0]  EXT_LOAD  = EXT_W'(EXT_STEPS);
    localparam logic [STEP_W-1:0] STEP_PRE  = STEP_W'(4);
    localparam logic [STEP_W-1:0] STEP_HOLD = STEP_W'(5);

    state_t             state_q,    state_d;
    logic [TMR_W-1:0]   tmr_q,      tmr_d;
    logic [EXT_W-1:0]   ext_left_q, ext_left_d;
    logic [STEP_W-1:0]  counter_q,  counter_d;
    logic [FARBE_W-1:0] farbe_q,    farbe_d;
    logic               req_q,      req_d;
    logic               ext_q,      ext_d;
    logic               ack_q,      ack_d;
    logic               knopf_edge;
    logic               tick;

    ampel_knopf_sync u_knopf_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .knopf      (knopf),
        .knopf_edge (knopf_edge)
    );

    assign tick = (tmr_q == TMR_LAST);

    // Next-state: step timer, request latch and RUN/EXTEND control.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tick ? '0 : tmr_q + TMR_W'(1);
        ext_left_d = ext_left_q;
        counter_d  = counter_q;
        req_d      = req_q;
        ack_d      = 1'b0;

        case (state_q)
            RUN: begin
                if (tick && (counter_q == STEP_PRE) && (req_q || knopf_edge)) begin
                    state_d    = EXTEND;
                    ext_left_d = EXT_LOAD;
                    ack_d      = 1'b1;
                    req_d      = 1'b0;
                    counter_d  = STEP_HOLD;
                end else begin
                    if (tick) begin
                        counter_d = counter_q + STEP_W'(1);
                    end
                    if (knopf_edge) begin
                        req_d = 1'b1;
                    end
                end
            end
            // Step 5 is frozen; button edges are deliberately dropped here.
            EXTEND: begin
                if (tick) begin
                    ext_left_d = ext_left_q - EXT_W'(1);
                    if (ext_left_q == EXT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        ext_d   = (state_d == EXTEND);
        farbe_d = farbe_of(counter_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            tmr_q      <= '0;
            ext_left_q <= '0;
            counter_q  <= '0;
            farbe_q    <= ROT_GELB;
            req_q      <= 1'b0;
            ext_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ext_left_q <= ext_left_d;
            counter_q  <= counter_d;
            farbe_q    <= farbe_d;
            req_q      <= req_d;
            ext_q      <= ext_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.counter     = counter_q;
    assign bus.ampelfarbe  = farbe_q;
    assign bus.req_pending = req_q;
    assign bus.ext_active  = ext_q;
    assign bus.knopf_ack   = ack_q;

endmodule
